// File: rtl/coin_acceptor.sv
// Coin acceptor front end: syncs and debounces two coin sensors, then
// emits one single-cycle coin code per coin with a quiet gap between codes.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   shilling_in  raw shilling sensor (async, bouncy)
//   crown_in     raw crown sensor (async, bouncy)
//   coin         registered code {crown, shilling}, one cycle per coin
//   busy         gap running or a coin pending
//   dropped      sticky: a coin was lost because its pending slot was full
//   lock         (COIN_REJECT_EN only) machine locked, new coins refused
//   reject       (COIN_REJECT_EN only) one-cycle pulse for a refused coin
//
// Optional feature macro: COIN_REJECT_EN
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GAP_CYCLES      = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       shilling_in,
    input  logic       crown_in,
`ifdef COIN_REJECT_EN
    input  logic       lock,
    output logic       reject,
`endif
    output logic [1:0] coin,
    output logic       busy,
    output logic       dropped
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);

    // Channel 0 is shilling, channel 1 is crown, matching the coin code.
    logic [1:0]    raw;
    logic [1:0]    s1;
    logic [1:0]    s2;
    logic [1:0]    deb;
    logic [1:0]    deb_q;
    logic [CW-1:0] cnt [2];
    logic [1:0]    rise;
    logic [1:0]    acc;
    logic [1:0]    want;
    logic [1:0]    pend;
    logic [GW-1:0] gap;

    assign raw = {crown_in, shilling_in};

    // Sync chain and debouncer: a new level is adopted only after it has
    // been seen for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1    <= '0;
            s2    <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1    <= raw;
            s2    <= s1;
            deb_q <= deb;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Only rising debounced edges mean a coin; falls are ignored.
    assign rise = deb & ~deb_q;

`ifdef COIN_REJECT_EN
    assign acc = rise & {2{~lock}};
`else
    assign acc = rise;
`endif

    assign want = pend | acc;
    assign busy = (gap != '0) || (pend != '0);

    // Emitter: outside the gap, pending and fresh coins merge into one
    // code; inside the gap, fresh coins wait in a one-deep slot each.
    always_ff @(posedge clk) begin
        if (reset) begin
            coin    <= 2'b00;
            pend    <= '0;
            gap     <= '0;
            dropped <= 1'b0;
        end else if (gap == '0) begin
            coin <= want;
            pend <= '0;
            if (want != 2'b00) begin
                gap <= GAP_LOAD;
            end
        end else begin
            coin <= 2'b00;
            gap  <= gap - 1'b1;
            pend <= pend | acc;
            if ((acc & pend) != 2'b00) begin
                dropped <= 1'b1;
            end
        end
    end

`ifdef COIN_REJECT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            reject <= 1'b0;
        end else begin
            reject <= |(rise & {2{lock}});
        end
    end
`endif

endmodule
